// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with same-cycle hits and a 4-beat line refill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module inst_cache #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES*WORDS];

    logic [TAG_W-1:0]      line_tag;
    logic [INDEX_W-1:0]    line_idx;
    logic [OFFSET_W-1:0]   beat;
    logic [OFFSET_W-1:0]   beat_next;
    logic                  flushed;

    logic [TAG_W-1:0]      pc_tag;
    logic [INDEX_W-1:0]    pc_idx;
    logic [OFFSET_W-1:0]   pc_word;
    logic                  hit;
    logic                  miss;
    logic                  beat_ack;
    logic                  last_ack;
    logic                  unused_pc_bits;

    assign pc_tag         = pc_i[31 -: TAG_W];
    assign pc_idx         = pc_i[OFFSET_W+2 +: INDEX_W];
    assign pc_word        = pc_i[2 +: OFFSET_W];
    assign unused_pc_bits = ^pc_i[1:0];

    assign hit       = ce_i & valid[pc_idx] & (tag_mem[pc_idx] == pc_tag) & (state == IDLE);
    assign miss      = ce_i & ~hit & (state == IDLE);
    assign beat_ack  = (state == REFILL) & mem_ack_i;
    assign last_ack  = beat_ack & (beat == OFFSET_W'(WORDS - 1));
    assign beat_next = beat + OFFSET_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        inst_o       = '0;
        inst_valid_o = 1'b0;
        stallreq_o   = miss | (state != IDLE);
        if (hit) begin
            inst_o       = data_mem[{pc_idx, pc_word}];
            inst_valid_o = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            line_tag   <= '0;
            line_idx   <= '0;
            beat       <= '0;
            flushed    <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state      <= REFILL;
                        line_tag   <= pc_tag;
                        line_idx   <= pc_idx;
                        beat       <= '0;
                        flushed    <= 1'b0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {pc_tag, pc_idx, {OFFSET_W{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    // A flush mid-refill poisons the line but never abandons the bus.
                    if (flush_i) flushed <= 1'b1;
                    if (mem_ack_i) begin
                        beat       <= beat_next;
                        mem_addr_o <= {line_tag, line_idx, beat_next, 2'b00};
                        if (last_ack) begin
                            state      <= DONE;
                            mem_req_o  <= 1'b0;
                            mem_addr_o <= '0;
                            if (!flushed && !flush_i) valid[line_idx] <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (flush_i) valid <= '0;
        end
    end

    // NOTE: the data and tag arrays are deliberately not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (beat_ack) data_mem[{line_idx, beat}] <= mem_rdata_i;
        if (last_ack) tag_mem[line_idx] <= line_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
